fmrv32im_mul: RTL
=================

FMRV32IM_MUL -- requirements
Module: fmrv32im_mul

Interface
REQ-001 SHALL have RST_N  input  1  asynchronous active-low reset.
REQ-002 SHALL have CLK  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have INST_MUL  input  1  request low 32 bits of RS1*RS2.
REQ-004 SHALL have INST_MULH  input  1  request high 32 bits, signed x signed.
REQ-005 SHALL have INST_MULHSU  input  1  request high 32 bits, signed RS1 x unsigned RS2.
REQ-006 SHALL have INST_MULHU  input  1  request high 32 bits, unsigned x unsigned.
REQ-007 SHALL have RS1  input  32  multiplicand operand.
REQ-008 SHALL have RS2  input  32  multiplier operand.
REQ-009 SHALL have WAIT  output  1  unit busy; the pipeline stalls while high.
REQ-010 SHALL have READY  output  1  one-cycle result-valid strobe.
REQ-011 SHALL have RD  output  32  registered result.

Function
REQ-012 SHALL implement a three-state FSM: S_IDLE, S_EXEC, S_FIN.
REQ-013 start SHALL be the OR of the four INST_* inputs; start SHALL be sampled only in S_IDLE and ignored in S_EXEC and S_FIN.
REQ-014 If more than one INST_* is high, priority SHALL be MULH > MULHSU > MULHU > MUL.
REQ-015 On start in S_IDLE the unit SHALL register the following and move to S_EXEC:
- RS1 signed for MULH/MULHSU; RS2 signed for MULH only.
- Each operand converted to a 32-bit magnitude: two's-complement negate if signed and bit31=1; 0x80000000 stays 0x80000000.
- outsign = (RS1 signed & RS1[31]) XOR (RS2 signed & RS2[31]).
- Selected op (low vs high half).
- 64-bit accumulator = 0; 5-bit iteration counter = 0.
REQ-016 S_EXEC SHALL perform one shift-add step per cycle for exactly 32 cycles, with no early termination:
- If the current multiplier LSB = 1, add the multiplicand (64-bit, shifted left by the iteration count) to the accumulator.
- Shift the multiplier right by 1; increment the counter.
REQ-017 On the clock edge that completes iteration 32, the FSM SHALL enter S_FIN and register RD in the same edge:
- P = outsign ? 64-bit two's-complement negate of the accumulator : the accumulator.
- RD = P[31:0] for MUL; RD = P[63:32] otherwise.
REQ-018 S_FIN SHALL last exactly one cycle, then return to S_IDLE.
REQ-019 WAIT SHALL be high whenever state != S_IDLE, i.e. 33 consecutive cycles per operation.
REQ-020 READY SHALL be high only in S_FIN; RD SHALL already hold the new result in that cycle.
REQ-021 RD SHALL hold its value from S_FIN until the next operation's S_FIN or reset.
REQ-022 A start asserted in the S_FIN cycle SHALL be ignored; the earliest accepted start SHALL be the first S_IDLE cycle after S_FIN.
REQ-023 A zero operand SHALL yield RD=0 regardless of outsign.
REQ-024 Operand inputs SHALL NOT affect an operation after capture; RS1/RS2 may change during S_EXEC.

Reset
REQ-025 RST_N low SHALL asynchronously force:
- state = S_IDLE; WAIT = 0; READY = 0; RD = 0.
- Accumulator, operands, counter, outsign and op-select = 0.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no READY pulse; the first start after RST_N deasserts SHALL execute normally.

Verification
REQ-027 MUL RS1=0x00000007, RS2=0xFFFFFFFD -> WAIT high 33 cycles, READY 1 cycle, RD=0xFFFFFFEB.
REQ-028 MULH 0x80000000 x 0x80000000 -> RD=0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> RD=0xFFFFFFFE.
REQ-029 MULHSU RS1=0xFFFFFFFF, RS2=0xFFFFFFFF -> RD=0xFFFFFFFF; MULH 0xFFFFFFFF x 0x00000000 -> RD=0x00000000.
REQ-030 Start MULHU 3x5, then assert INST_MUL with RS1=9, RS2=9 during S_EXEC and S_FIN -> RD=0x00000000, a single READY pulse, and no second operation.
REQ-031 Reset pulsed at S_EXEC cycle 10 -> WAIT=0, READY=0, RD=0 immediately; a subsequent MUL 6x7 -> RD=0x0000002A after 33 cycles.
REQ-032 Back-to-back: MUL 2x3, then MUL 4x5 issued at the first S_IDLE cycle after READY -> RD=6, then RD=20, with READY 34 cycles apart.

Source files
------------

// File: rtl/fmrv32im_mul_if.sv
// Request/response bundle between the pipeline and the iterative multiplier.
// The pipeline is the master: it raises an INST_* line with operands and stalls on WAIT.
interface fmrv32im_mul_if;
   logic        INST_MUL;
   logic        INST_MULH;
   logic        INST_MULHSU;
   logic        INST_MULHU;
   logic [31:0] RS1;
   logic [31:0] RS2;
   logic        WAIT;
   logic        READY;
   logic [31:0] RD;

   modport master (
      output INST_MUL, INST_MULH, INST_MULHSU, INST_MULHU, RS1, RS2,
      input  WAIT, READY, RD
   );

   modport slave (
      input  INST_MUL, INST_MULH, INST_MULHSU, INST_MULHU, RS1, RS2,
      output WAIT, READY, RD
   );
endinterface

// File: rtl/fmrv32im_mul.sv
// RV32M multiplier: sign-magnitude shift-add, one bit per cycle, fixed 32 iterations.
// WAIT covers the 32 execute cycles plus the one-cycle result strobe.
module fmrv32im_mul (
   input  logic              RST_N,
   input  logic              CLK,
   fmrv32im_mul_if.slave     bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_FIN
   } state_t;

   state_t      state;
   logic [63:0] mcand;
   logic [31:0] mplier;
   logic [63:0] acc;
   logic [4:0]  count;
   logic        outsign;
   logic        sel_high;
   logic        wait_r;
   logic        ready_r;
   logic [31:0] rd_r;

   logic        start;
   logic        rs1_signed;
   logic        rs2_signed;
   logic        rs1_neg;
   logic        rs2_neg;
   logic [31:0] rs1_mag;
   logic [31:0] rs2_mag;
   logic [63:0] acc_step;
   logic [63:0] prod;

   // MULH outranks MULHSU, which outranks MULHU; MUL only applies when none of the
   // high-half requests is present, so signedness and half-select fall out directly.
   always_comb begin
      start      = bus.INST_MUL | bus.INST_MULH | bus.INST_MULHSU | bus.INST_MULHU;
      rs1_signed = bus.INST_MULH | bus.INST_MULHSU;
      rs2_signed = bus.INST_MULH;
      rs1_neg    = rs1_signed & bus.RS1[31];
      rs2_neg    = rs2_signed & bus.RS2[31];
      rs1_mag    = rs1_neg ? (32'd0 - bus.RS1) : bus.RS1;
      rs2_mag    = rs2_neg ? (32'd0 - bus.RS2) : bus.RS2;
   end

   // The multiplicand register is pre-shifted each step, so adding it is the same as
   // adding the original magnitude shifted by the iteration count.
   always_comb begin
      acc_step = acc + (mplier[0] ? mcand : 64'd0);
      prod     = outsign ? (64'd0 - acc_step) : acc_step;
   end

   // Single state machine; WAIT, READY and RD are all registered here.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= S_IDLE;
         mcand    <= 64'd0;
         mplier   <= 32'd0;
         acc      <= 64'd0;
         count    <= 5'd0;
         outsign  <= 1'b0;
         sel_high <= 1'b0;
         wait_r   <= 1'b0;
         ready_r  <= 1'b0;
         rd_r     <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  mcand    <= {32'd0, rs1_mag};
                  mplier   <= rs2_mag;
                  acc      <= 64'd0;
                  count    <= 5'd0;
                  outsign  <= rs1_neg ^ rs2_neg;
                  sel_high <= bus.INST_MULH | bus.INST_MULHSU | bus.INST_MULHU;
                  wait_r   <= 1'b1;
                  state    <= S_EXEC;
               end
            end

            S_EXEC: begin
               acc    <= acc_step;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + 5'd1;
               if (count == 5'd31) begin
                  rd_r    <= sel_high ? prod[63:32] : prod[31:0];
                  ready_r <= 1'b1;
                  state   <= S_FIN;
               end
            end

            S_FIN: begin
               ready_r <= 1'b0;
               wait_r  <= 1'b0;
               state   <= S_IDLE;
            end

            default: begin
               ready_r <= 1'b0;
               wait_r  <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.WAIT  = wait_r;
   assign bus.READY = ready_r;
   assign bus.RD    = rd_r;

endmodule
